seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the width of the sampled data word.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the good/error counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, a data beat is present this cycle.
REQ-006 SHALL have port in_data, input, DATA_W, the captured word from the upstream register stage.
REQ-007 SHALL have port clear, input, 1, a synchronous soft restart of checking.
REQ-008 SHALL have port locked, output, 1, high while the checker is in LOCKED.
REQ-009 SHALL have port err_pulse, output, 1, a one-cycle pulse per detected mismatch.
REQ-010 SHALL have port expected, output, DATA_W, the next expected word.
REQ-011 SHALL have port good_cnt, output, CNT_W, the count of matched beats.
REQ-012 SHALL have port err_cnt, output, CNT_W, the count of mismatched beats.

Function
REQ-013 SHALL implement FSM states HUNT, LOCKED and FAIL.
REQ-014 In HUNT, a valid beat SHALL seed expected = in_data+1 and enter LOCKED; good_cnt and err_cnt are unchanged.
REQ-015 In LOCKED, a valid beat with in_data==expected SHALL increment expected and good_cnt.
REQ-016 In LOCKED, a valid beat with in_data!=expected SHALL increment err_cnt, assert err_pulse, enter FAIL and hold expected.
REQ-017 All outputs SHALL be registered, so effects appear one cycle after the sampling edge; err_pulse is high for exactly one cycle per mismatch.
REQ-018 expected SHALL wrap modulo 2^DATA_W, so 0xFF followed by 0x00 is a match.
REQ-019 good_cnt and err_cnt SHALL saturate at all-ones and never wrap.
REQ-020 Cycles with in_valid=0 SHALL change no state, counter or expected value.
REQ-021 clear SHALL return the FSM to HUNT, zero both counters, zero expected and suppress err_pulse, taking priority over a same-cycle valid beat, which is ignored.
REQ-022 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-023 rst SHALL force state=HUNT, locked=0, err_pulse=0, expected=0, good_cnt=0 and err_cnt=0 on the next clk edge.
REQ-024 rst SHALL have priority over clear and in_valid.
REQ-025 rst asserted mid-sequence SHALL discard all history; the first valid beat after release reseeds per REQ-014.

Configuration
REQ-026 The macro SEQ_CHECKER_RESYNC_EN SHALL select FAIL-state behaviour.
- Defined: in FAIL, the next valid beat reseeds expected = in_data+1 and returns to LOCKED without counting as good or error.
- Undefined: FAIL is sticky and only clear or rst leaves it; valid beats in FAIL are ignored and not counted.

Structure
REQ-027 Package seq_checker_pkg SHALL hold the state enum typedef (HUNT, LOCKED, FAIL) and the default-width localparams.
REQ-028 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), instantiated twice.

Verification
REQ-029 The bench SHALL cover: reset, then beats 1,2,3,4 -> locked=1 from the cycle after beat 1, good_cnt=3, err_cnt=0, expected=5.
REQ-030 The bench SHALL cover: lock on 0xFE, then beats 0xFF,0x00,0x01 -> good_cnt=3, expected=0x02, no err_pulse.
REQ-031 The bench SHALL cover: beats 1,2,7 -> err_pulse high for exactly one cycle, err_cnt=1, locked=0, expected=3.
REQ-032 The bench SHALL cover: after REQ-031, beats 9,10 -> RESYNC_EN: locked=1, good_cnt=2, expected=11; without it: locked=0 and counters unchanged.
REQ-033 The bench SHALL cover: clear asserted together with a valid beat while LOCKED -> next cycle state=HUNT, counters=0, beat ignored, no err_pulse.
REQ-034 The bench SHALL cover: CNT_W=2 with 6 matching beats after lock -> good_cnt stays at 3; and rst in the middle of a stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared types and default widths for the incrementing-sequence checker.
// Optional FAIL-state resynchronisation is selected by SEQ_CHECKER_RESYNC_EN.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        FAIL   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Reset and clear both zero it; reset wins.
module sat_counter
    import seq_checker_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_C = {W{1'b1}};
    localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

    // count register with reset > clear > saturating increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + ONE_C;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Checks that valid beats form a +1 sequence (mod 2^DATA_W) once locked.
// Define SEQ_CHECKER_RESYNC_EN to let the FAIL state reseed on the next beat.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [DATA_W-1:0] expected,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [DATA_W-1:0] ONE_C = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] expected_r;
    logic [DATA_W-1:0] expected_next_s;
    logic              locked_r;
    logic              err_pulse_r;
    logic              err_next_s;
    logic              good_inc_s;
    logic              err_inc_s;

    // next-state, next-expected and counter strobes; clear overrides any beat
    always_comb begin
        state_next_s    = state_r;
        expected_next_s = expected_r;
        good_inc_s      = 1'b0;
        err_inc_s       = 1'b0;
        err_next_s      = 1'b0;
        if (clear) begin
            state_next_s    = HUNT;
            expected_next_s = {DATA_W{1'b0}};
        end else if (in_valid) begin
            case (state_r)
                HUNT: begin
                    expected_next_s = in_data + ONE_C;
                    state_next_s    = LOCKED;
                end
                LOCKED: begin
                    if (in_data == expected_r) begin
                        expected_next_s = expected_r + ONE_C;
                        good_inc_s      = 1'b1;
                    end else begin
                        err_inc_s    = 1'b1;
                        err_next_s   = 1'b1;
                        state_next_s = FAIL;
                    end
                end
                FAIL: begin
`ifdef SEQ_CHECKER_RESYNC_EN
                    expected_next_s = in_data + ONE_C;
                    state_next_s    = LOCKED;
`else
                    state_next_s    = FAIL;
`endif
                end
                default: begin
                    state_next_s    = HUNT;
                    expected_next_s = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            state_next_s    = state_r;
            expected_next_s = expected_r;
        end
    end

    // state, expected word and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            expected_r  <= {DATA_W{1'b0}};
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            expected_r  <= expected_next_s;
            locked_r    <= (state_next_s == LOCKED);
            err_pulse_r <= err_next_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (good_inc_s),
        .cnt (good_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_inc_s),
        .cnt (err_cnt)
    );

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign expected  = expected_r;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker; a second instance with CNT_W=2 checks saturation.
// Expected values depend on SEQ_CHECKER_RESYNC_EN for the FAIL-recovery step.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        clear = 1'b0;
    logic        locked, err_pulse;
    logic [7:0]  expected;
    logic [15:0] good_cnt, err_cnt;
    logic        locked2, err_pulse2;
    logic [7:0]  expected2;
    logic [1:0]  good_cnt2, err_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .expected(expected),
        .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    seq_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked2), .err_pulse(err_pulse2), .expected(expected2),
        .good_cnt(good_cnt2), .err_cnt(err_cnt2)
    );

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic c);
        rst = r; in_valid = v; in_data = d; clear = c;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic ep,
                           input logic [7:0] ex, input logic [15:0] gc, input logic [15:0] ec);
        chk({tag, ".locked"},    {31'd0, locked},    {31'd0, lk});
        chk({tag, ".err_pulse"}, {31'd0, err_pulse}, {31'd0, ep});
        chk({tag, ".expected"},  {24'd0, expected},  {24'd0, ex});
        chk({tag, ".good_cnt"},  {16'd0, good_cnt},  {16'd0, gc});
        chk({tag, ".err_cnt"},   {16'd0, err_cnt},   {16'd0, ec});
    endtask

    initial begin
        // reset wins over a simultaneous clear and valid beat
        cyc(1'b1, 1'b1, 8'd5, 1'b1);
        chk_all("reset", 1'b0, 1'b0, 8'd0, 16'd0, 16'd0);

        // lock on 1, then 2,3,4 match
        cyc(1'b0, 1'b1, 8'd1, 1'b0);
        chk_all("seed1", 1'b1, 1'b0, 8'd2, 16'd0, 16'd0);
        cyc(1'b0, 1'b1, 8'd2, 1'b0);
        cyc(1'b0, 1'b1, 8'd3, 1'b0);
        cyc(1'b0, 1'b1, 8'd4, 1'b0);
        chk_all("seq1234", 1'b1, 1'b0, 8'd5, 16'd3, 16'd0);
        cyc(1'b0, 1'b0, 8'd99, 1'b0);
        chk_all("idle", 1'b1, 1'b0, 8'd5, 16'd3, 16'd0);

        // six more matches: wide counter reaches 9, 2-bit counter pinned at 3
        for (int i = 5; i <= 10; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        chk_all("run10", 1'b1, 1'b0, 8'd11, 16'd9, 16'd0);
        chk("sat.good_cnt2", {30'd0, good_cnt2}, 32'd3);
        chk("sat.err_cnt2",  {30'd0, err_cnt2},  32'd0);

        // reset mid-stream discards history; next beat reseeds
        cyc(1'b1, 1'b1, 8'd11, 1'b0);
        chk_all("midrst", 1'b0, 1'b0, 8'd0, 16'd0, 16'd0);
        chk("midrst.good_cnt2", {30'd0, good_cnt2}, 32'd0);
        cyc(1'b0, 1'b1, 8'hFE, 1'b0);
        chk_all("seedFE", 1'b1, 1'b0, 8'hFF, 16'd0, 16'd0);
        cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        chk_all("wrapFF", 1'b1, 1'b0, 8'h00, 16'd1, 16'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk_all("wrap00", 1'b1, 1'b0, 8'h01, 16'd2, 16'd0);
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        chk_all("wrap01", 1'b1, 1'b0, 8'h02, 16'd3, 16'd0);

        // clear with a matching beat while locked: beat ignored
        cyc(1'b0, 1'b1, 8'h02, 1'b1);
        chk_all("clear", 1'b0, 1'b0, 8'd0, 16'd0, 16'd0);
        cyc(1'b0, 1'b0, 8'h03, 1'b0);
        chk_all("clear_idle", 1'b0, 1'b0, 8'd0, 16'd0, 16'd0);

        // mismatch: 1,2,7
        cyc(1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 8'd1, 1'b0);
        cyc(1'b0, 1'b1, 8'd2, 1'b0);
        chk_all("pre_err", 1'b1, 1'b0, 8'd3, 16'd1, 16'd0);
        cyc(1'b0, 1'b1, 8'd7, 1'b0);
        chk_all("err7", 1'b0, 1'b1, 8'd3, 16'd1, 16'd1);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        chk_all("err_once", 1'b0, 1'b0, 8'd3, 16'd1, 16'd1);

        // beats in FAIL: resync or sticky depending on build
        cyc(1'b0, 1'b1, 8'd9, 1'b0);
`ifdef SEQ_CHECKER_RESYNC_EN
        chk_all("resync9", 1'b1, 1'b0, 8'd10, 16'd1, 16'd1);
        cyc(1'b0, 1'b1, 8'd10, 1'b0);
        chk_all("resync10", 1'b1, 1'b0, 8'd11, 16'd2, 16'd1);
`else
        chk_all("sticky9", 1'b0, 1'b0, 8'd3, 16'd1, 16'd1);
        cyc(1'b0, 1'b1, 8'd10, 1'b0);
        chk_all("sticky10", 1'b0, 1'b0, 8'd3, 16'd1, 16'd1);
`endif

        // clear leaves any state and zeroes counters
        cyc(1'b0, 1'b1, 8'd50, 1'b1);
        chk_all("clear2", 1'b0, 1'b0, 8'd0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
